// File: rtl/tmds_encoder.sv
// DVI 8b/10b TMDS encoder for one colour lane: 8-bit data or 2 control bits in, one 10-bit symbol out per clk.
// Latency: 2 register stages (q_m, then symbol + running disparity); no backpressure, accepts every cycle.
module tmds_encoder #(
    parameter logic [9:0] RESET_SYMBOL = 10'h354
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic [1:0] ctrl,
    input  logic [7:0] data,
    output logic [9:0] tmds
);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // Transition-minimising stage: bit 8 records which chain (1 = XOR, 0 = XNOR) was used.
    function automatic logic [8:0] transition_min(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] q;
        ones     = popcount8(d);
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    logic [8:0]        s1_qm;
    logic              s1_de;
    logic [1:0]        s1_ctrl;
    logic signed [4:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_qm   <= '0;
            s1_de   <= 1'b0;
            s1_ctrl <= 2'b00;
        end else begin
            s1_qm   <= transition_min(data);
            s1_de   <= de;
            s1_ctrl <= ctrl;
        end
    end

    logic [3:0]        qm_ones;
    logic signed [4:0] qm_disp;
    logic              cnt_pos;
    logic              cnt_neg;
    logic              disp_pos;
    logic              disp_neg;
    logic [9:0]        tmds_d;
    logic signed [4:0] cnt_d;

    // qm_disp = ones - zeros of q_m[7:0] = 2*ones - 8, always within -8..+8.
    assign qm_ones  = popcount8(s1_qm[7:0]);
    assign qm_disp  = $signed({qm_ones, 1'b0}) - 5'sd8;
    assign cnt_neg  = cnt[4];
    assign cnt_pos  = !cnt[4] && (cnt != 5'sd0);
    assign disp_neg = qm_disp[4];
    assign disp_pos = !qm_disp[4] && (qm_disp != 5'sd0);

    always_comb begin
        tmds_d = {1'b0, s1_qm[8], s1_qm[7:0]};
        cnt_d  = cnt + qm_disp - (s1_qm[8] ? 5'sd0 : 5'sd2);
        if (!s1_de) begin
            case (s1_ctrl)
                2'b00:   tmds_d = 10'h354;
                2'b01:   tmds_d = 10'h0AB;
                2'b10:   tmds_d = 10'h154;
                default: tmds_d = 10'h2AB;
            endcase
            cnt_d = 5'sd0;
        end else if ((cnt == 5'sd0) || (qm_disp == 5'sd0)) begin
            tmds_d = s1_qm[8] ? {2'b01, s1_qm[7:0]} : {2'b10, ~s1_qm[7:0]};
            cnt_d  = s1_qm[8] ? (cnt + qm_disp) : (cnt - qm_disp);
        end else if ((cnt_pos && disp_pos) || (cnt_neg && disp_neg)) begin
            // Invert the payload to pull the running disparity back toward zero.
            tmds_d = {1'b1, s1_qm[8], ~s1_qm[7:0]};
            cnt_d  = cnt + (s1_qm[8] ? 5'sd2 : 5'sd0) - qm_disp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmds <= RESET_SYMBOL;
            cnt  <= 5'sd0;
        end else begin
            tmds <= tmds_d;
            cnt  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed vector table plus reset corner cases and a long random DC-balance run for tmds_encoder.
module tb_tmds_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [9:0] tmds;

    int errors = 0;
    int checks = 0;

    tmds_encoder #(.RESET_SYMBOL(10'h354)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .de    (de),
        .ctrl  (ctrl),
        .data  (data),
        .tmds  (tmds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic [9:0] exp_tmds;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[20];

    task automatic check_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 10'h%h expected 10'h%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit ok, input int act);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: value %0d out of range", name, act);
        end
    endtask

    task automatic step(input logic d_e, input logic [1:0] c, input logic [7:0] d);
        de   = d_e;
        ctrl = c;
        data = d;
        @(posedge clk);
        #1;
    endtask

    // Reference encoder written straight from the DVI algorithm using integer arithmetic.
    task automatic ref_enc(input logic [7:0] d, inout int rc, output logic [9:0] sym);
        int   ones;
        int   n1;
        int   n0;
        bit   xn;
        logic [8:0] q;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(q[i]);
        n0 = 8 - n1;
        if (rc == 0 || n1 == n0) begin
            if (q[8]) begin
                sym = {2'b01, q[7:0]};
                rc  = rc + n1 - n0;
            end else begin
                sym = {2'b10, ~q[7:0]};
                rc  = rc + n0 - n1;
            end
        end else if ((rc > 0 && n1 > n0) || (rc < 0 && n0 > n1)) begin
            sym = {1'b1, q[8], ~q[7:0]};
            rc  = rc + 2 * int'(q[8]) + n0 - n1;
        end else begin
            sym = {1'b0, q[8], q[7:0]};
            rc  = rc + n1 - n0 - (q[8] ? 0 : 2);
        end
    endtask

    function automatic logic [7:0] ref_dec(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    function automatic int sym_disp(input logic [9:0] s);
        int ones;
        ones = 0;
        for (int i = 0; i < 10; i++) ones += int'(s[i]);
        return 2 * ones - 10;
    endfunction

    int         mcnt;
    int         rsum;
    int         dcnt;
    logic [7:0] rd;
    logic [7:0] prev_d;
    logic [9:0] exp_sym;
    logic [9:0] prev_sym;

    initial begin
        vecs[0]  = '{1'b0, 2'b00, 8'h00, 10'h354,  0};
        vecs[1]  = '{1'b0, 2'b01, 8'h00, 10'h0AB,  0};
        vecs[2]  = '{1'b0, 2'b10, 8'h00, 10'h154,  0};
        vecs[3]  = '{1'b0, 2'b11, 8'h00, 10'h2AB,  0};
        vecs[4]  = '{1'b1, 2'b00, 8'h00, 10'h100, -8};
        vecs[5]  = '{1'b1, 2'b00, 8'h00, 10'h3FF,  2};
        vecs[6]  = '{1'b1, 2'b00, 8'h00, 10'h100, -6};
        vecs[7]  = '{1'b0, 2'b00, 8'h00, 10'h354,  0};
        vecs[8]  = '{1'b1, 2'b00, 8'hFF, 10'h200, -8};
        vecs[9]  = '{1'b0, 2'b00, 8'h00, 10'h354,  0};
        vecs[10] = '{1'b1, 2'b00, 8'h00, 10'h100, -8};
        vecs[11] = '{1'b0, 2'b01, 8'h00, 10'h0AB,  0};
        vecs[12] = '{1'b1, 2'b00, 8'h00, 10'h100, -8};
        vecs[13] = '{1'b0, 2'b10, 8'hFF, 10'h154,  0};
        vecs[14] = '{1'b1, 2'b11, 8'h00, 10'h100, -8};
        vecs[15] = '{1'b0, 2'b00, 8'h00, 10'h354,  0};
        vecs[16] = '{1'b1, 2'b00, 8'h01, 10'h1FF,  8};
        vecs[17] = '{1'b1, 2'b00, 8'h01, 10'h300,  2};
        vecs[18] = '{1'b1, 2'b00, 8'h55, 10'h133,  2};
        vecs[19] = '{1'b1, 2'b00, 8'h00, 10'h100, -6};

        // Reset held for 3 clocks with random inputs.
        rst_n = 1'b0;
        de    = 1'b1;
        ctrl  = 2'b00;
        data  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            de   = 1'($urandom);
            ctrl = 2'($urandom);
            data = 8'($urandom);
            @(posedge clk);
            #1;
            check_sym("reset_hold", tmds, 10'h354);
        end
        check_int("reset_cnt", int'(dut.cnt), 0);
        rst_n = 1'b1;

        // Table: after step j the output reflects row j-1.
        for (int j = 0; j <= 20; j++) begin
            if (j < 20) step(vecs[j].de, vecs[j].ctrl, vecs[j].data);
            else        step(1'b0, 2'b00, 8'h00);
            if (j == 0) begin
                check_sym("first_out", tmds, 10'h354);
            end else begin
                check_sym($sformatf("vec%0d_tmds", j - 1), tmds, vecs[j-1].exp_tmds);
                check_int($sformatf("vec%0d_cnt", j - 1), int'(dut.cnt), vecs[j-1].exp_cnt);
            end
        end

        // Asynchronous reset mid-stream discards both in-flight symbols.
        step(1'b1, 2'b00, 8'h00);
        step(1'b1, 2'b00, 8'h00);
        check_sym("pre_reset_sym", tmds, 10'h100);
        #2;
        rst_n = 1'b0;
        #1;
        check_sym("async_reset_sym", tmds, 10'h354);
        check_int("async_reset_cnt", int'(dut.cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        de    = 1'b0;
        ctrl  = 2'b01;
        data  = 8'h00;
        @(posedge clk);
        #1;
        check_sym("post_reset_flush", tmds, 10'h354);
        @(posedge clk);
        #1;
        check_sym("post_reset_ctrl", tmds, 10'h0AB);

        // Random active video: model match, decode round-trip, disparity bounds.
        step(1'b0, 2'b00, 8'h00);
        mcnt     = 0;
        rsum     = 0;
        prev_d   = 8'h00;
        prev_sym = 10'h000;
        for (int i = 0; i <= 10000; i++) begin
            rd = 8'($urandom);
            ref_enc(rd, mcnt, exp_sym);
            step(1'b1, 2'b00, rd);
            if (i > 0) begin
                check_sym("rand_sym", tmds, prev_sym);
                check_int("rand_decode", int'(ref_dec(tmds)), int'(prev_d));
                rsum += sym_disp(tmds);
                check_true("rand_running_sum", rsum >= -10 && rsum <= 10, rsum);
                dcnt = int'(dut.cnt);
                check_true("rand_cnt_bound", dcnt >= -8 && dcnt <= 8, dcnt);
            end
            prev_d   = rd;
            prev_sym = exp_sym;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
